// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, data and debug/loader requesters.
// Optional build macro: MEM_ARB_RR_EN selects round-robin instead of dbg > dm > if.
module mem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_be,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  input  logic                dbg_lock,
  output logic                locked,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_LOCK
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM,
    OWN_DBG
  } own_t;

  state_t     state;
  own_t       owner;
  logic [2:0] lat_cnt;
  logic       lock_q;

  logic       rd_done;
  logic       free;
  logic       dbg_only;
  logic [2:0] req_v;
  logic [2:0] gnt_v;
  logic       rd_gnt;

  assign rd_done  = (state == ST_RD) && (lat_cnt == 3'd1);
  // A slot opens when idle/locked, or in the cycle the pending read returns.
  assign free     = rst_n && ((state != ST_RD) || rd_done);
  assign dbg_only = lock_q || dbg_lock;

  assign req_v[0] = if_req  && free && !dbg_only;
  assign req_v[1] = dm_req  && free && !dbg_only;
  assign req_v[2] = dbg_req && free;

`ifdef MEM_ARB_RR_EN
  logic [1:0] rr_ptr;

  always_comb begin
    gnt_v = '0;
    case (rr_ptr)
      2'd1: begin
        if (req_v[1])      gnt_v[1] = 1'b1;
        else if (req_v[2]) gnt_v[2] = 1'b1;
        else if (req_v[0]) gnt_v[0] = 1'b1;
      end
      2'd2: begin
        if (req_v[2])      gnt_v[2] = 1'b1;
        else if (req_v[0]) gnt_v[0] = 1'b1;
        else if (req_v[1]) gnt_v[1] = 1'b1;
      end
      default: begin
        if (req_v[0])      gnt_v[0] = 1'b1;
        else if (req_v[1]) gnt_v[1] = 1'b1;
        else if (req_v[2]) gnt_v[2] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else begin
      unique case (1'b1)
        gnt_v[0]: rr_ptr <= 2'd1;
        gnt_v[1]: rr_ptr <= 2'd2;
        gnt_v[2]: rr_ptr <= 2'd0;
        default:  rr_ptr <= rr_ptr;
      endcase
    end
  end
`else
  always_comb begin
    gnt_v = '0;
    if (req_v[2])      gnt_v[2] = 1'b1;
    else if (req_v[1]) gnt_v[1] = 1'b1;
    else if (req_v[0]) gnt_v[0] = 1'b1;
  end
`endif

  assign if_gnt  = gnt_v[0];
  assign dm_gnt  = gnt_v[1];
  assign dbg_gnt = gnt_v[2];
  assign mem_en  = |gnt_v;

  assign rd_gnt = gnt_v[0]
                | (gnt_v[1] && !dm_we)
                | (gnt_v[2] && !dbg_we);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    unique case (1'b1)
      gnt_v[0]: begin
        mem_addr = if_addr;
      end
      gnt_v[1]: begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_be    = dm_be;
      end
      gnt_v[2]: begin
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_be    = dbg_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= OWN_NONE;
      lat_cnt <= 3'd0;
      lock_q  <= 1'b0;
    end else if (free) begin
      lock_q <= dbg_lock;
      if (rd_gnt) begin
        state   <= ST_RD;
        lat_cnt <= LAT;
        unique case (1'b1)
          gnt_v[0]: owner <= OWN_IF;
          gnt_v[1]: owner <= OWN_DM;
          default:  owner <= OWN_DBG;
        endcase
      end else begin
        state   <= dbg_lock ? ST_LOCK : ST_IDLE;
        lat_cnt <= 3'd0;
        owner   <= OWN_NONE;
      end
    end else begin
      lat_cnt <= lat_cnt - 3'd1;
    end
  end

  assign if_rvalid  = rd_done && (owner == OWN_IF);
  assign dm_rvalid  = rd_done && (owner == OWN_DM);
  assign dbg_rvalid = rd_done && (owner == OWN_DBG);
  assign locked     = lock_q;
  assign rdata      = mem_rdata;

endmodule
